// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and operating-mode constants.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result bundle of the serial adder/subtractor; the requester drives
// Start/Sub/A/B, the arithmetic unit returns Busy/Done and the held result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
    output Start, Sub, A, B,
    input  Busy, Done, Sum, Cout, Overflow
  );

  modport slave (
    input  Start, Sub, A, B,
    output Busy, Done, Sum, Cout, Overflow
  );

endinterface

// File: rtl/serial_addsub_fa_cell.sv
// Single combinational full-adder cell shared by every bit position of the
// serial datapath.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Parametrised bit-serial adder/subtractor: one operand bit per clock, LSB
// first, through a single full-adder cell; result held until next completion.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  serial_addsub_if.slave bus
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             cell_sum;
  logic             cell_cout;

  serial_fa_cell u_cell (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .cin (carry),
    .sum (cell_sum),
    .cout(cell_cout)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.Start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the inverted operand and an initial carry of 1
  // are set up at capture; in the last bit, carry still holds the carry into the MSB.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_a   <= '0;
      op_b   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            op_a   <= bus.A;
            op_b   <= (bus.Sub == MODE_SUB) ? ~bus.B : bus.B;
            carry  <= (bus.Sub == MODE_SUB);
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        ST_RUN: begin
          res_sr <= {cell_sum, res_sr[WIDTH-1:1]};
          op_a   <= {1'b0, op_a[WIDTH-1:1]};
          op_b   <= {1'b0, op_b[WIDTH-1:1]};
          carry  <= cell_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q  <= {cell_sum, res_sr[WIDTH-1:1]};
            cout_q <= cell_cout;
            ovf_q  <= carry ^ cell_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state == ST_RUN);
  assign bus.Done     = (state == ST_DONE);
  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: WIDTH=8 and WIDTH=4 instances, directed
// vectors with hand-computed results, monitors checking every Done pulse.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t e8;
  exp_t e4;
  logic [7:0] last8;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(4)) bus4 ();

  serial_addsub #(.WIDTH(8)) dut8 (.Clock(Clock), .Reset(Reset), .bus(bus8.slave));
  serial_addsub #(.WIDTH(4)) dut4 (.Clock(Clock), .Reset(Reset), .bus(bus4.slave));

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Each Done pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge Clock) begin
    if (bus8.Done === 1'b1) begin
      if (q8.size() == 0) check_output("dut8 unexpected done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check_output("dut8 sum", bus8.Sum, e8.sum);
        check_output("dut8 cout", bus8.Cout, e8.cout);
        check_output("dut8 overflow", bus8.Overflow, e8.ovf);
        check_output("dut8 done cycle", cyc, e8.cyc);
      end
    end
    if (bus4.Done === 1'b1) begin
      if (q4.size() == 0) check_output("dut4 unexpected done", 1, 0);
      else begin
        e4 = q4.pop_front();
        check_output("dut4 sum", {4'h0, bus4.Sum}, e4.sum);
        check_output("dut4 cout", bus4.Cout, e4.cout);
        check_output("dut4 overflow", bus4.Overflow, e4.ovf);
        check_output("dut4 done cycle", cyc, e4.cyc);
      end
    end
  end

  task automatic apply_stimulus8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] es, input logic ec, input logic eo);
    @(negedge Clock);
    bus8.Start = 1'b1; bus8.Sub = sub; bus8.A = a; bus8.B = b;
    q8.push_back('{es, ec, eo, cyc + 1 + 8});
    @(negedge Clock);
    bus8.Start = 1'b0; bus8.Sub = ~sub; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
  endtask

  task automatic wait8(input logic [7:0] hold, input bit disturb);
    int busy_n = 0;
    int guard = 0;
    while (bus8.Done !== 1'b1 && guard < 40) begin
      check_output("dut8 busy in run", bus8.Busy, 1);
      check_output("dut8 sum held in run", bus8.Sum, hold);
      busy_n++;
      if (disturb && busy_n == 2) begin bus8.Start = 1'b1; bus8.A = 8'hFF; end
      else if (disturb && busy_n == 4) bus8.Start = 1'b0;
      @(negedge Clock);
      guard++;
    end
    check_output("dut8 done seen", bus8.Done, 1);
    check_output("dut8 busy cycles", busy_n, 8);
    check_output("dut8 busy low in done", bus8.Busy, 0);
    @(negedge Clock);
    check_output("dut8 done one cycle", bus8.Done, 0);
  endtask

  task automatic run4(input logic sub, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] es, input logic ec, input logic eo);
    int busy_n = 0;
    int guard = 0;
    @(negedge Clock);
    bus4.Start = 1'b1; bus4.Sub = sub; bus4.A = a; bus4.B = b;
    q4.push_back('{{4'h0, es}, ec, eo, cyc + 1 + 4});
    @(negedge Clock);
    bus4.Start = 1'b0; bus4.A = 4'hF; bus4.B = 4'hF;
    while (bus4.Done !== 1'b1 && guard < 20) begin
      busy_n += (bus4.Busy === 1'b1) ? 1 : 0;
      @(negedge Clock);
      guard++;
    end
    check_output("dut4 done seen", bus4.Done, 1);
    check_output("dut4 busy cycles", busy_n, 4);
    @(negedge Clock);
  endtask

  initial begin
    int dones = 0;
    int guard = 0;
    Reset = 1'b1;
    bus8.Start = 1'b0; bus8.Sub = MODE_ADD; bus8.A = '0; bus8.B = '0;
    bus4.Start = 1'b0; bus4.Sub = MODE_ADD; bus4.A = '0; bus4.B = '0;
    repeat (3) @(negedge Clock);
    check_output("reset busy", bus8.Busy, 0);
    check_output("reset done", bus8.Done, 0);
    check_output("reset sum", bus8.Sum, 0);
    check_output("reset cout", bus8.Cout, 0);
    check_output("reset overflow", bus8.Overflow, 0);
    check_output("reset dut4 sum", {4'h0, bus4.Sum}, 0);
    Reset = 1'b0;
    last8 = 8'h00;

    apply_stimulus8(MODE_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1); wait8(last8, 0); last8 = 8'h96;
    apply_stimulus8(MODE_SUB, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0); wait8(last8, 0); last8 = 8'hF0;
    apply_stimulus8(MODE_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1); wait8(last8, 0); last8 = 8'h7F;
    apply_stimulus8(MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0); wait8(last8, 0); last8 = 8'h00;
    apply_stimulus8(MODE_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1); wait8(last8, 0); last8 = 8'h80;
    apply_stimulus8(MODE_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0); wait8(last8, 1); last8 = 8'h02;

    // Start held high: the second operation starts WIDTH+2 cycles after the first.
    @(negedge Clock);
    bus8.Start = 1'b1; bus8.Sub = MODE_ADD; bus8.A = 8'h03; bus8.B = 8'h05;
    q8.push_back('{8'h08, 1'b0, 1'b0, cyc + 1 + 8});
    q8.push_back('{8'h08, 1'b0, 1'b0, cyc + 1 + 8 + 10});
    while (dones < 2 && guard < 60) begin
      @(negedge Clock);
      guard++;
      if (bus8.Done === 1'b1) dones++;
    end
    bus8.Start = 1'b0;
    check_output("held start two dones", dones, 2);
    repeat (12) @(negedge Clock);
    check_output("held start idle afterwards", bus8.Busy, 0);
    check_output("held start queue drained", q8.size(), 0);

    // Asynchronous reset three cycles into RUN discards the operation.
    @(negedge Clock);
    bus8.Start = 1'b1; bus8.A = 8'h5A; bus8.B = 8'h3C;
    @(negedge Clock);
    bus8.Start = 1'b0;
    repeat (2) @(negedge Clock);
    check_output("busy before reset", bus8.Busy, 1);
    #2 Reset = 1'b1;
    #1;
    check_output("async reset busy", bus8.Busy, 0);
    check_output("async reset done", bus8.Done, 0);
    check_output("async reset sum", bus8.Sum, 0);
    check_output("async reset cout", bus8.Cout, 0);
    check_output("async reset overflow", bus8.Overflow, 0);
    @(negedge Clock);
    Reset = 1'b0;
    last8 = 8'h00;
    repeat (2) @(negedge Clock);
    check_output("no done after reset", bus8.Done, 0);
    apply_stimulus8(MODE_ADD, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0); wait8(last8, 0); last8 = 8'h07;

    run4(MODE_ADD, 4'h9, 4'h8, 4'h1, 1'b1, 1'b1);
    run4(MODE_SUB, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0);

    repeat (4) @(negedge Clock);
    check_output("dut8 queue empty", q8.size(), 0);
    check_output("dut4 queue empty", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; successor to the fixed 4-bit serial adder.
- Captures two WIDTH-bit operands on a Start handshake and processes one bit per clock through a single full-adder cell, LSB first.
- Adds a subtract mode, signed overflow, and a Busy/Done handshake.
- Results are held stable in output registers.
- Sits in the datapath as a small-area arithmetic unit for multi-cycle ALU operations.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request to begin an operation; sampled only in IDLE.
Sub  input  1  mode sampled with Start: 0 = A+B, 1 = A-B.
A  input  WIDTH  first operand, sampled with Start.
B  input  WIDTH  second operand, sampled with Start.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle pulse when the result registers update.
Sum  output  WIDTH  result, held until the next completion.
Cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow (A >= B unsigned).
Overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state = IDLE; Busy = 0; Done = 0; Sum = 0; Cout = 0; Overflow = 0.
  - Internal shift registers, bit counter and carry cleared.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start = 1 at a rising edge: load opA <= A; opB <= (Sub ? ~B : B); carry <= Sub; cnt <= 0; clear the internal result shift register; go to RUN.
  - Start = 0: remain in IDLE.
- RUN, each edge:
  - The bit cell adds opA[0], opB[0], carry.
  - The result shift register shifts right with the cell sum entering at the MSB.
  - carry <= cell cout; opA and opB shift right with 0 fill; cnt++.
  - On the edge where cnt == WIDTH-1 (the last bit), the carry into that bit is recorded for overflow.
  - Also on that edge: Sum <= final shifted value, Cout <= cell cout, Overflow <= carry_in_msb ^ cell cout, Done <= 1; go to DONE.
- DONE: lasts exactly one cycle; Done = 1 only here. The next edge returns to IDLE with Done = 0.
- Latency: Start captured at edge k → Done high in the cycle following edge k+WIDTH; Sum/Cout/Overflow valid from that cycle.
- Throughput: one operation per WIDTH+2 cycles. Start may be held high; it is re-accepted at the first IDLE edge after DONE.
- Start while Busy or in DONE is ignored (no queueing).
- A, B and Sub changes after capture have no effect on the running operation.
- Sum, Cout and Overflow change only at the completion edge or on Reset. They are never partial values.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Counter width is clog2(WIDTH).

Decomposition:
- Shared package/header: state encoding constants (ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2) and mode constants (MODE_ADD = 0, MODE_SUB = 1).
- One sub-module, serial_fa_cell: a combinational 1-bit full adder (a, b, cin → sum, cout), instantiated once.
- FSM, counter and shift registers live in serial_addsub.

Test Plan:
1. WIDTH=8; Reset pulse, then Start with Sub=0, A=8'h5A, B=8'h3C → Busy for 8 cycles; Done pulses exactly once, 8 cycles after the Start edge; Sum=8'h96, Cout=0, Overflow=1.
2. WIDTH=8; Sub=1, A=8'h10, B=8'h20 → Sum=8'hF0, Cout=0 (borrow), Overflow=0. Then Sub=1, A=8'h80, B=8'h01 → Sum=8'h7F, Cout=1, Overflow=1.
3. WIDTH=8; Sub=0, A=8'hFF, B=8'h01 → Sum=8'h00, Cout=1, Overflow=0. Prior result stays stable on Sum throughout the RUN phase.
4. WIDTH=8; A=8'h01, B=8'h01 started. During RUN, pulse Start and change A to 8'hFF → both ignored; Sum=8'h02. Start held high continuously → a new operation begins at the first IDLE edge after Done.
5. WIDTH=8; assert Reset asynchronously 3 cycles into RUN → Busy, Done, Sum, Cout and Overflow go to 0 immediately. Next Start 8'h03+8'h04 → Sum=8'h07 after a full 8-cycle latency.
6. WIDTH=4 regression; Sub=0, A=4'h9, B=4'h8 → Sum=4'h1, Cout=1, Overflow=1; Done 4 cycles after the Start edge.
